imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//   Synthesizable successor to hierarchical instruction-memory preloading. Receives a byte stream
//   over a valid/ready handshake, assembles INSTR_WIDTH-bit words MSB-first and writes them to
//   instruction memory from address 0. Holds the CPU in reset until loading completes.
//   Sits between a host byte source (UART/JTAG bridge) and the CPU's instruction memory write port.
// PARAMETERS
//   INSTR_WIDTH  24  instruction width in bits; must be a multiple of 8
//   DEPTH        64  instruction memory depth in words
//   ADDR_WIDTH   6   memory address width; ADDR_WIDTH = $clog2(DEPTH)
//   (localparam BYTES_PER_WORD = INSTR_WIDTH/8)
// PORTS
//   clk          in   1            system clock, rising edge
//   rst          in   1            synchronous active-high reset
//   start        in   1            one-cycle pulse; begins a load from IDLE, DONE or ERROR
//   in_data      in   8            stream byte
//   in_valid     in   1            in_data valid
//   in_ready     out  1            loader accepts a byte; transfer occurs when in_valid & in_ready
//   mem_we       out  1            instruction memory write strobe
//   mem_addr     out  ADDR_WIDTH   write address
//   mem_wdata    out  INSTR_WIDTH  write data
//   cpu_hold     out  1            CPU reset; 1 = CPU held
//   done         out  1            load completed successfully (level)
//   error        out  1            load aborted (level)
//   words_loaded out  16           number of words written in the current load
// BEHAVIOUR
//   Reset: state=IDLE; cpu_hold=1; in_ready=0; mem_we=0; mem_addr=0; mem_wdata=0; done=0;
//     error=0; words_loaded=0. rst mid-load aborts immediately; no further writes occur.
//   Stream format: 2-byte word count N (MSB first), then N*BYTES_PER_WORD data bytes (MSB first).
//   FSM: IDLE -start-> HDR. HDR accepts 2 bytes, then:
//     N > DEPTH -> ERROR; N == 0 -> DONE (or CHK); otherwise -> DATA.
//     DATA -> DONE (or CHK) after the last byte of word N.
//     DONE/ERROR -start-> HDR, clearing done, error, words_loaded and the address.
//   in_ready=1 only in HDR, DATA and CHK. A byte is accepted only when in_valid & in_ready.
//   Bytes arriving while in_valid=0 or in_ready=0 are not consumed.
//   Write: mem_we pulses for 1 cycle, the cycle after the last byte of a word is accepted.
//     mem_addr equals the word index (0..N-1). words_loaded increments with each mem_we.
//     Back-to-back words cost no extra cycles.
//   cpu_hold=1 in all states except DONE. done=1 only in DONE; error=1 only in ERROR.
//   start while in HDR, DATA or CHK is ignored. start coincident with rst: rst wins.
//   No address wrap: the N <= DEPTH check guarantees mem_addr <= DEPTH-1.
// CONFIGURATION
//   LOADER_CHECKSUM_EN defined:
//     - A running XOR covers all header and data bytes.
//     - After the last data byte, state CHK accepts one byte.
//     - Byte == XOR -> DONE; otherwise -> ERROR, with cpu_hold kept at 1.
//     - Memory writes already done are not undone.
//   LOADER_CHECKSUM_EN undefined: there is no CHK state and no trailing byte is expected.
// STRUCTURE
//   loader_pkg.vh: FSM state encodings (IDLE, HDR, DATA, CHK, DONE, ERROR), HDR_BYTES=2,
//     and the COUNT_WIDTH=16 constant.
//   Sub-module byte_assembler: shift register plus byte counter.
//     Emits word_valid and word after BYTES_PER_WORD accepted bytes.
//     Cleared by rst and by the loader's restart.
// TESTING
//   1. Reset, then start; send 00 03 followed by 9 bytes for words 0x02C070, 0x018400, 0x008400.
//      -> mem_we at addresses 0,1,2 with those words; done=1; cpu_hold=0; words_loaded=3.
//   2. Send header 00 41 (N=65 > 64) -> error=1; in_ready=0; no mem_we; cpu_hold=1.
//   3. Send header 00 00 -> done=1 with no writes (with checksum: trailing byte 00 required).
//   4. Toggle in_valid randomly during scenario 1 -> identical writes and result.
//      No byte is consumed while in_valid=0.
//   5. Assert rst after the 5th data byte of scenario 1 -> outputs return to reset values.
//      A later start plus full stream -> correct load.
//   6. LOADER_CHECKSUM_EN: scenario 1 with a correct XOR byte -> done.
//      Same stream with checksum ^ 0x01 -> error=1; cpu_hold=1; words_loaded=3.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Checksum support is selected by the LOADER_CHECKSUM_EN macro in imem_boot_loader.sv.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_CHK   = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } loader_state_e;

  localparam int HDR_BYTES   = 2;
  localparam int COUNT_WIDTH = 16;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader,
// plus a debug view of the loader FSM state.
interface imem_boot_loader_if #(
  parameter int INSTR_WIDTH = 24,
  parameter int ADDR_WIDTH  = 6
);
  import imem_boot_loader_pkg::*;

  // Stream handshake: a byte moves on a rising clk edge where in_valid & in_ready;
  // the source holds in_data stable while in_valid is high and not yet accepted.
  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [INSTR_WIDTH-1:0] mem_wdata;
  loader_state_e          state;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, state
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, state
  );

endinterface

// File: rtl/imem_boot_loader_byte_assembler.sv
// Packs accepted bytes MSB-first into INSTR_WIDTH-bit words; word_valid_o is a
// one-cycle pulse in the cycle after the final byte of a word is accepted.
module imem_boot_loader_byte_assembler #(
  parameter int INSTR_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   byte_valid_i,
  input  logic [7:0]             byte_i,
  output logic                   last_byte_o,
  output logic                   word_valid_o,
  output logic [INSTR_WIDTH-1:0] word_o
);

  localparam int BPW   = INSTR_WIDTH / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [INSTR_WIDTH-1:0] shift_q, shift_d;
  logic [INSTR_WIDTH-1:0] word_q, word_d;
  logic                   valid_q, valid_d;
  logic [INSTR_WIDTH-1:0] merged;

  assign merged      = (shift_q << 8) | INSTR_WIDTH'(byte_i);
  assign last_byte_o = byte_valid_i && (cnt_q == CNT_W'(BPW - 1));

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      if (last_byte_o) begin
        cnt_d   = '0;
        shift_d = '0;
        word_d  = merged;
        valid_d = 1'b1;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        shift_d = merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_valid_o = valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a counted image into instruction memory and releases the CPU when done.
// Define LOADER_CHECKSUM_EN to require a trailing XOR byte over header and data.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = 24,
  parameter int DEPTH       = 64,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  imem_boot_loader_if.slave      bus,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] words_loaded
);

  localparam int HDR_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e END_STATE = S_CHK;
`else
  localparam loader_state_e END_STATE = S_DONE;
`endif

  loader_state_e          state_q, state_d;
  logic [HDR_W-1:0]       hdr_cnt_q, hdr_cnt_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [COUNT_WIDTH-1:0] loaded_q, loaded_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             xor_q, xor_d;
`endif

  logic                   in_ready;
  logic                   accept;
  logic                   restart;
  logic                   last_byte;
  logic                   word_valid;
  logic [INSTR_WIDTH-1:0] word;
  logic [COUNT_WIDTH-1:0] hdr_value;

  assign in_ready  = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
  assign accept    = bus.in_valid && in_ready;
  assign hdr_value = {count_q[COUNT_WIDTH-9:0], bus.in_data};

  imem_boot_loader_byte_assembler #(
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_asm (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (restart),
    .byte_valid_i (accept && (state_q == S_DATA)),
    .byte_i       (bus.in_data),
    .last_byte_o  (last_byte),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    count_d   = count_q;
    wcnt_d    = wcnt_q;
    loaded_d  = loaded_q;
    addr_d    = addr_q;
    restart   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    xor_d     = xor_q;
    if (accept && (state_q != S_CHK)) xor_d = xor_q ^ bus.in_data;
`endif

    // The address stops on the final word so it never wraps past DEPTH-1.
    if (word_valid) begin
      loaded_d = loaded_q + COUNT_WIDTH'(1);
      if ((loaded_q + COUNT_WIDTH'(1)) < count_q) addr_d = addr_q + ADDR_WIDTH'(1);
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d   = S_HDR;
          restart   = 1'b1;
          hdr_cnt_d = '0;
          count_d   = '0;
          wcnt_d    = '0;
          loaded_d  = '0;
          addr_d    = '0;
`ifdef LOADER_CHECKSUM_EN
          xor_d     = 8'h00;
`endif
        end
      end
      S_HDR: begin
        if (accept) begin
          count_d = hdr_value;
          if (hdr_cnt_q == HDR_W'(HDR_BYTES - 1)) begin
            if (hdr_value > COUNT_WIDTH'(DEPTH)) state_d = S_ERROR;
            else if (hdr_value == '0)            state_d = END_STATE;
            else                                 state_d = S_DATA;
          end else begin
            hdr_cnt_d = hdr_cnt_q + HDR_W'(1);
          end
        end
      end
      S_DATA: begin
        if (last_byte) begin
          wcnt_d = wcnt_q + COUNT_WIDTH'(1);
          if (wcnt_q == (count_q - COUNT_WIDTH'(1))) state_d = END_STATE;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) state_d = (bus.in_data == xor_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hdr_cnt_q <= '0;
      count_q   <= '0;
      wcnt_q    <= '0;
      loaded_q  <= '0;
      addr_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q     <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      count_q   <= count_d;
      wcnt_q    <= wcnt_d;
      loaded_q  <= loaded_d;
      addr_q    <= addr_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q     <= xor_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = word_valid;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = word;
  assign bus.state     = state_q;

  assign cpu_hold     = (state_q != S_DONE);
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERROR);
  assign words_loaded = loaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader; memory writes are checked against
// an expected queue filled as word bytes are driven.
module tb_imem_boot_loader;
  import imem_boot_loader_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int errors = 0;
  int checks = 0;

  logic [29:0] exp_q[$];
  logic [23:0] img [64];

  imem_boot_loader_if #(.INSTR_WIDTH(24), .ADDR_WIDTH(6)) bus ();

  imem_boot_loader #(
    .INSTR_WIDTH (24),
    .DEPTH       (64),
    .ADDR_WIDTH  (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and score any memory write seen in the new cycle.
  task automatic step();
    logic [29:0] exp;
    @(posedge clk);
    #1;
    if (bus.mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%h, no write expected", bus.mem_addr, bus.mem_wdata);
      end else begin
        exp = exp_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== exp) begin
          errors++;
          $display("FAIL mem_write: addr=%0d data=%h expected addr=%0d data=%h",
                   bus.mem_addr, bus.mem_wdata, exp[29:24], exp[23:0]);
        end
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        step();
      end
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready === 1'b1) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte %h not accepted within 20 cycles", b);
    end
  endtask

  task automatic send_word(input int idx, input bit gaps, inout logic [7:0] x);
    logic [7:0] bt;
    for (int b = 0; b < 3; b++) begin
      bt = img[idx][23 - 8*b -: 8];
      if (b == 2) exp_q.push_back({6'(idx), img[idx]});
      send_byte(bt, gaps);
      x = x ^ bt;
    end
  endtask

  task automatic load_image(input int n, input bit gaps, input bit bad_chk, input bit mid_start);
    logic [7:0]  x;
    logic [15:0] nn;
    nn = 16'(n);
    x  = 8'h00;
    pulse_start();
    send_byte(nn[15:8], gaps);
    x = x ^ nn[15:8];
    send_byte(nn[7:0], gaps);
    x = x ^ nn[7:0];
    if (n <= 64) begin
      for (int w = 0; w < n; w++) begin
        send_word(w, gaps, x);
        if (mid_start && w == 0) pulse_start();
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(bad_chk ? (x ^ 8'h01) : x, gaps);
`else
      if (bad_chk) x = 8'h00;
`endif
    end
    bus.in_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic check_end(input string name, input bit exp_done, input logic [15:0] exp_wl);
    checks++;
    if (done !== exp_done) begin
      errors++;
      $display("FAIL %s_done: got %b expected %b", name, done, exp_done);
    end
    checks++;
    if (error !== !exp_done) begin
      errors++;
      $display("FAIL %s_error: got %b expected %b", name, error, !exp_done);
    end
    checks++;
    if (cpu_hold !== !exp_done) begin
      errors++;
      $display("FAIL %s_cpu_hold: got %b expected %b", name, cpu_hold, !exp_done);
    end
    checks++;
    if (words_loaded !== exp_wl) begin
      errors++;
      $display("FAIL %s_words_loaded: got %0d expected %0d", name, words_loaded, exp_wl);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_in_ready: got %b expected 0", name, bus.in_ready);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending_writes: %0d writes missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({cpu_hold, bus.in_ready, bus.mem_we, done, error} !== 5'b10000) begin
      errors++;
      $display("FAIL %s_flags: hold/ready/we/done/err=%b expected 10000", name,
               {cpu_hold, bus.in_ready, bus.mem_we, done, error});
    end
    checks++;
    if (bus.mem_addr !== 6'd0 || bus.mem_wdata !== 24'd0) begin
      errors++;
      $display("FAIL %s_mem_bus: addr=%0d data=%h expected 0/000000", name, bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (words_loaded !== 16'd0) begin
      errors++;
      $display("FAIL %s_words_loaded: got %0d expected 0", name, words_loaded);
    end
  endtask

  task automatic set_basic();
    img[0] = 24'h02C070;
    img[1] = 24'h018400;
    img[2] = 24'h008400;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    set_basic();
    load_image(3, 1'b0, 1'b0, 1'b0);
    check_end("basic", 1'b1, 16'd3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) img[i] = 24'($urandom);
    load_image(3, 1'b0, 1'b0, 1'b0);
    check_end("reload", 1'b1, 16'd3);
  endtask

  task automatic test_overflow();
    load_image(65, 1'b0, 1'b0, 1'b0);
    check_end("overflow", 1'b0, 16'd0);
  endtask

  task automatic test_empty();
    load_image(0, 1'b0, 1'b0, 1'b0);
    check_end("empty", 1'b1, 16'd0);
  endtask

  task automatic test_full_depth();
    for (int i = 0; i < 64; i++) img[i] = 24'($urandom);
    load_image(64, 1'b0, 1'b0, 1'b0);
    check_end("full_depth", 1'b1, 16'd64);
  endtask

  task automatic test_random_valid();
    set_basic();
    load_image(3, 1'b1, 1'b0, 1'b0);
    check_end("random_valid", 1'b1, 16'd3);
  endtask

  task automatic test_start_ignored();
    set_basic();
    load_image(3, 1'b1, 1'b0, 1'b1);
    check_end("start_ignored", 1'b1, 16'd3);
  endtask

  task automatic test_reset_mid();
    logic [7:0] x;
    set_basic();
    x = 8'h00;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_word(0, 1'b0, x);
    send_byte(img[1][23:16], 1'b0);
    send_byte(img[1][15:8], 1'b0);
    rst = 1'b1;
    step();
    check_reset_outputs("reset_mid");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_pending: %0d writes missing, expected 0", exp_q.size());
      exp_q.delete();
    end
    step();
    rst = 1'b0;
    repeat (2) step();
    check_reset_outputs("reset_mid_hold");
    load_image(3, 1'b0, 1'b0, 1'b0);
    check_end("reset_mid_reload", 1'b1, 16'd3);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    set_basic();
    load_image(3, 1'b0, 1'b0, 1'b0);
    check_end("checksum_good", 1'b1, 16'd3);
    load_image(3, 1'b0, 1'b1, 1'b0);
    check_end("checksum_bad", 1'b0, 16'd3);
  endtask
`endif

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_empty();
    test_full_depth();
    test_random_valid();
    test_start_ignored();
    test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
